// File: rtl/mesh_term_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mesh_arb_pkg : packet field layout, FSM states, terminal destination check
// Revision     : 1.0
// ============================================================================
package mesh_arb_pkg;

   // Field positions are offsets down from the packet MSB, so they hold for any pckg_sz
   localparam int NXTJP_MSB = 0;
   localparam int NXTJP_W   = 8;
   localparam int ROW_MSB   = 8;
   localparam int COL_MSB   = 12;
   localparam int MODE_BIT  = 16;
   localparam int COORD_W   = 4;

   typedef enum logic {IDLE, SEND} arb_state_t;

   function automatic logic dest_valid(
      input logic [3:0] row,
      input logic [3:0] colum,
      input int         rows,
      input int         colums,
      input logic [7:0] bdcst
   );
      logic w_row_in, w_col_in, w_row_edge, w_col_edge, w_bcast;
      w_row_in   = (int'(row) >= 1) && (int'(row) <= rows);
      w_col_in   = (int'(colum) >= 1) && (int'(colum) <= colums);
      w_row_edge = (row == 4'd0) || (int'(row) == rows + 1);
      w_col_edge = (colum == 4'd0) || (int'(colum) == colums + 1);
      w_bcast    = (row == bdcst[3:0]) && (colum == bdcst[7:4]);
      return (w_row_in && w_col_edge) || (w_col_in && w_row_edge) || w_bcast;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_term_arbiter_if.sv
`default_nettype none
// ============================================================================
// mesh_term_arbiter_if : requester FIFOs and router terminal handshake bundle
// Revision             : 1.0
// ============================================================================
interface mesh_term_arbiter_if #(
   parameter int N_REQ   = 4,
   parameter int pckg_sz = 40
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]              req_push;
   logic [N_REQ-1:0][pckg_sz-1:0] req_data;
   logic [N_REQ-1:0]              req_full;
   logic                          pndng;
   logic [pckg_sz-1:0]            data_out;
   logic                          popin;
   logic [ID_W-1:0]               grant_id;
   logic [15:0]                   drop_cnt;

   modport master (
      output req_push, req_data, popin,
      input  req_full, pndng, data_out, grant_id, drop_cnt
   );

   modport slave (
      input  req_push, req_data, popin,
      output req_full, pndng, data_out, grant_id, drop_cnt
   );
endinterface
`default_nettype wire

// File: rtl/mesh_term_arbiter_port_fifo.sv
`default_nettype none
// ============================================================================
// port_fifo : per-requester synchronous FIFO with registered full/empty flags
// Revision  : 1.0
// ============================================================================
module port_fifo #(
   parameter int pckg_sz    = 40,
   parameter int fifo_depth = 4
) (
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic               i_push,
   input  wire logic               i_pop,
   input  wire logic [pckg_sz-1:0] i_din,
   output logic      [pckg_sz-1:0] o_dout,
   output logic                    o_empty,
   output logic                    o_full
);
   localparam int AW = $clog2(fifo_depth);
   localparam logic [AW:0] c_full_cnt = (AW+1)'(fifo_depth);

   logic [pckg_sz-1:0] r_mem [fifo_depth];
   logic [AW-1:0]      r_wr;
   logic [AW-1:0]      r_rd;
   logic [AW:0]        r_cnt;
   logic               r_full;
   logic               r_empty;
   logic               w_push;
   logic               w_pop;
   logic [AW:0]        w_cnt_nxt;

   // A full FIFO refuses a push even when it is popped in the same cycle
   assign w_push = i_push && !r_full;
   assign w_pop  = i_pop && !r_empty;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_push && !w_pop)
         w_cnt_nxt = r_cnt + 1'b1;
      else if (!w_push && w_pop)
         w_cnt_nxt = r_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push)
            r_wr <= r_wr + 1'b1;
         if (w_pop)
            r_rd <= r_rd + 1'b1;
         r_cnt   <= w_cnt_nxt;
         r_full  <= (w_cnt_nxt == c_full_cnt);
         r_empty <= (w_cnt_nxt == '0);
      end
   end

   assign o_dout  = r_mem[r_rd];
   assign o_empty = r_empty;
   assign o_full  = r_full;

endmodule
`default_nettype wire

// File: rtl/mesh_term_arbiter.sv
`default_nettype none
// ============================================================================
// mesh_term_arbiter : round-robin injection of N_REQ requester FIFOs into one
//                     mesh terminal port; non-terminal destinations are dropped
// Revision          : 1.0
// ============================================================================
module mesh_term_arbiter
   import mesh_arb_pkg::*;
#(
   parameter int         ROWS       = 4,
   parameter int         COLUMS     = 4,
   parameter int         pckg_sz    = 40,
   parameter int         fifo_depth = 4,
   parameter int         N_REQ      = 4,
   parameter logic [7:0] bdcst      = {8{1'b1}}
) (
   input wire logic           clk,
   input wire logic           reset,
   mesh_term_arbiter_if.slave bus
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   w_empty;
   logic [N_REQ-1:0]   w_full;
   logic [N_REQ-1:0]   w_pop;
   logic [pckg_sz-1:0] w_dout [N_REQ];

   arb_state_t         r_state;
   logic               r_pndng;
   logic [pckg_sz-1:0] r_data;
   logic [ID_W-1:0]    r_grant;
   logic [ID_W-1:0]    r_last;
   logic [15:0]        r_drop;

   logic               w_found;
   logic [ID_W-1:0]    w_win;
   int                 w_idx;
   logic               w_sel;
   logic [pckg_sz-1:0] w_head;
   logic [pckg_sz-1:0] w_pkt;
   logic [3:0]         w_row;
   logic [3:0]         w_col;
   logic               w_valid;

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_fifo
         port_fifo #(
            .pckg_sz    (pckg_sz),
            .fifo_depth (fifo_depth)
         ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (bus.req_push[gi]),
            .i_pop   (w_pop[gi]),
            .i_din   (bus.req_data[gi]),
            .o_dout  (w_dout[gi]),
            .o_empty (w_empty[gi]),
            .o_full  (w_full[gi])
         );
      end
   endgenerate

   // First non-empty FIFO scanning upward from the one after the last winner
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = int'(r_last) + 1 + i;
         if (w_idx >= N_REQ)
            w_idx = w_idx - N_REQ;
         if (!w_found && !w_empty[w_idx]) begin
            w_found = 1'b1;
            w_win   = ID_W'(w_idx);
         end
      end
   end

   assign w_sel = w_found && ((r_state == IDLE) || bus.popin);

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < N_REQ; i++)
         w_pop[i] = w_sel && (w_win == ID_W'(i));
   end

   assign w_head  = w_dout[w_win];
   assign w_row   = w_head[pckg_sz-1-ROW_MSB -: COORD_W];
   assign w_col   = w_head[pckg_sz-1-COL_MSB -: COORD_W];
   assign w_valid = dest_valid(w_row, w_col, ROWS, COLUMS, bdcst);

   // The packet enters the mesh with its hop field cleared
   always_comb begin
      w_pkt = w_head;
      w_pkt[pckg_sz-1-NXTJP_MSB -: NXTJP_W] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_pndng <= 1'b0;
         r_data  <= '0;
         r_grant <= '0;
         r_last  <= ID_W'(N_REQ - 1);
         r_drop  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_sel) begin
                  r_last <= w_win;
                  if (w_valid) begin
                     r_data  <= w_pkt;
                     r_grant <= w_win;
                     r_pndng <= 1'b1;
                     r_state <= SEND;
                  end else if (r_drop != 16'hFFFF) begin
                     r_drop <= r_drop + 16'd1;
                  end
               end
            end
            SEND: begin
               if (bus.popin) begin
                  if (w_sel) begin
                     r_last <= w_win;
                     if (w_valid) begin
                        r_data  <= w_pkt;
                        r_grant <= w_win;
                     end else begin
                        r_pndng <= 1'b0;
                        r_state <= IDLE;
                        if (r_drop != 16'hFFFF)
                           r_drop <= r_drop + 16'd1;
                     end
                  end else begin
                     r_pndng <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_pndng <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_full = w_full;
   assign bus.pndng    = r_pndng;
   assign bus.data_out = r_data;
   assign bus.grant_id = r_grant;
   assign bus.drop_cnt = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mesh_term_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mesh_term_arbiter : scoreboard bench for the mesh terminal arbiter
// Revision             : 1.0
// ============================================================================
module tb_mesh_term_arbiter;
   localparam int N = 4;
   localparam int W = 40;

   typedef struct {
      logic [1:0]   id;
      logic [W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_drop = 0;

   always #5 clk = ~clk;

   mesh_term_arbiter_if #(.N_REQ(N), .pckg_sz(W)) bus ();

   mesh_term_arbiter #(
      .ROWS(4), .COLUMS(4), .pckg_sz(W), .fifo_depth(4), .N_REQ(N), .bdcst(8'hFF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [W-1:0] mk(input logic [7:0] nx, input logic [3:0] r,
                                       input logic [3:0] c, input logic m, input logic [22:0] pl);
      return {nx, r, c, m, pl};
   endfunction

   function automatic bit tb_ok(input logic [W-1:0] p);
      int r, c;
      r = int'(p[31:28]);
      c = int'(p[27:24]);
      if (r == 15 && c == 15) return 1'b1;
      if (r >= 1 && r <= 4 && (c == 0 || c == 5)) return 1'b1;
      if (c >= 1 && c <= 4 && (r == 0 || r == 5)) return 1'b1;
      return 1'b0;
   endfunction

   // Drive one push and record what the router should eventually see
   task automatic drive(input int id, input logic [W-1:0] p);
      exp_t e;
      bus.req_push[id] = 1'b1;
      bus.req_data[id] = p;
      if (tb_ok(p)) begin
         e.id   = 2'(id);
         e.data = {8'h00, p[31:0]};
         sb.push_back(e);
      end else begin
         exp_drop++;
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset        = 1'b1;
      bus.req_push = '0;
      bus.req_data = '0;
      bus.popin    = 1'b0;
      sb.delete();
      exp_drop = 0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      n_checks++;
      if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL reset_pndng: got %b want 0", bus.pndng); end
      n_checks++;
      if (bus.data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.data_out); end
      n_checks++;
      if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
      n_checks++;
      if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt); end
      n_checks++;
      if (bus.req_full !== 4'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0000", bus.req_full); end
   endtask

   task automatic test_single;
      exp_t e;
      do_reset();
      drive(1, mk(8'h00, 4'h1, 4'h5, 1'b1, 23'h15));
      step();
      bus.req_push = '0;
      n_checks++;
      if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL single_early: pndng got %b want 0", bus.pndng); end
      step();
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL single_sb: got empty want 1 entry"); end
      else begin
         e = sb.pop_front();
         if ({bus.pndng, bus.grant_id, bus.data_out} !== {1'b1, e.id, e.data}) begin
            n_fail++;
            $display("FAIL single_pkt: got p=%b g=%0d d=%h want p=1 g=%0d d=%h",
                     bus.pndng, bus.grant_id, bus.data_out, e.id, e.data);
         end
      end
      bus.popin = 1'b1;
      step();
      bus.popin = 1'b0;
      n_checks++;
      if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL single_pop: pndng got %b want 0", bus.pndng); end
   endtask

   task automatic test_round_robin;
      exp_t e;
      do_reset();
      for (int i = 0; i < N; i++)
         drive(i, mk(8'h00, 4'(i + 1), 4'h0, 1'b0, 23'(16'hA00 + i)));
      step();
      bus.req_push = '0;
      bus.popin    = 1'b1;
      step();
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (sb.size() == 0) begin n_fail++; $display("FAIL rr_sb: got empty want entry %0d", i); end
         else begin
            e = sb.pop_front();
            if ({bus.pndng, bus.grant_id, bus.data_out} !== {1'b1, e.id, e.data}) begin
               n_fail++;
               $display("FAIL rr_pkt%0d: got p=%b g=%0d d=%h want p=1 g=%0d d=%h",
                        i, bus.pndng, bus.grant_id, bus.data_out, e.id, e.data);
            end
         end
         step();
      end
      n_checks++;
      if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL rr_end: pndng got %b want 0", bus.pndng); end
      bus.popin = 1'b0;
   endtask

   task automatic test_drop;
      exp_t e;
      do_reset();
      drive(2, mk(8'h00, 4'h0, 4'h0, 1'b0, 23'h7));
      step();
      drive(2, mk(8'h00, 4'h2, 4'h5, 1'b0, 23'h123));
      step();
      bus.req_push = '0;
      n_checks++;
      if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL drop_pndng: got %b want 0", bus.pndng); end
      n_checks++;
      if (bus.drop_cnt !== 16'(exp_drop)) begin n_fail++; $display("FAIL drop_cnt: got %0d want %0d", bus.drop_cnt, exp_drop); end
      step();
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL drop_sb: got empty want 1 entry"); end
      else begin
         e = sb.pop_front();
         if ({bus.pndng, bus.grant_id, bus.data_out} !== {1'b1, e.id, e.data}) begin
            n_fail++;
            $display("FAIL drop_next: got p=%b g=%0d d=%h want p=1 g=%0d d=%h",
                     bus.pndng, bus.grant_id, bus.data_out, e.id, e.data);
         end
      end
      bus.popin = 1'b1;
      step();
      bus.popin = 1'b0;
      n_checks++;
      if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL drop_pop: pndng got %b want 0", bus.pndng); end
   endtask

   task automatic test_full;
      exp_t e;
      logic [W-1:0] p;
      do_reset();
      // Park the arbiter in SEND so requester 0's FIFO is not drained
      drive(1, mk(8'h00, 4'h3, 4'h0, 1'b0, 23'h1));
      step();
      bus.req_push = '0;
      step();
      for (int k = 0; k < 5; k++) begin
         p = mk(8'h00, 4'h0, 4'(k % 4 + 1), 1'b1, 23'(k + 32));
         if (k < 4) drive(0, p);
         else begin bus.req_push[0] = 1'b1; bus.req_data[0] = p; end
         step();
         n_checks++;
         if (bus.req_full[0] !== (k >= 3)) begin
            n_fail++;
            $display("FAIL full_flag%0d: got %b want %b", k, bus.req_full[0], (k >= 3));
         end
      end
      bus.req_push = '0;
      bus.popin    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (sb.size() == 0) begin n_fail++; $display("FAIL full_sb: got empty want entry %0d", i); end
         else begin
            e = sb.pop_front();
            if ({bus.pndng, bus.grant_id, bus.data_out} !== {1'b1, e.id, e.data}) begin
               n_fail++;
               $display("FAIL full_pkt%0d: got p=%b g=%0d d=%h want p=1 g=%0d d=%h",
                        i, bus.pndng, bus.grant_id, bus.data_out, e.id, e.data);
            end
         end
         step();
         if (i == 0) begin
            n_checks++;
            if (bus.req_full[0] !== 1'b0) begin n_fail++; $display("FAIL full_release: got %b want 0", bus.req_full[0]); end
         end
      end
      n_checks++;
      if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL full_extra: pndng got %b want 0", bus.pndng); end
      bus.popin = 1'b0;
   endtask

   task automatic test_reset_mid;
      bit seen;
      do_reset();
      drive(0, mk(8'h00, 4'h0, 4'h0, 1'b0, 23'h2));
      step();
      bus.req_push = '0;
      step();
      for (int i = 1; i < N; i++)
         drive(i, mk(8'h00, 4'h5, 4'(i), 1'b0, 23'(i)));
      step();
      bus.req_push = '0;
      step();
      n_checks++;
      if (bus.pndng !== 1'b1) begin n_fail++; $display("FAIL rst_mid_send: pndng got %b want 1", bus.pndng); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      sb.delete();
      n_checks++;
      if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pndng: got %b want 0", bus.pndng); end
      n_checks++;
      if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_drop: got %0d want 0", bus.drop_cnt); end
      n_checks++;
      if (bus.req_full !== 4'b0) begin n_fail++; $display("FAIL rst_mid_full: got %b want 0000", bus.req_full); end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.pndng !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL rst_mid_quiet: got pndng=1 after reset want 0"); end
   endtask

   task automatic test_broadcast;
      exp_t e;
      do_reset();
      drive(3, mk(8'hA5, 4'hF, 4'hF, 1'b1, 23'h5A5A5));
      step();
      bus.req_push = '0;
      step();
      n_checks++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL bcast_sb: got empty want 1 entry"); end
      else begin
         e = sb.pop_front();
         if ({bus.pndng, bus.grant_id, bus.data_out} !== {1'b1, e.id, e.data}) begin
            n_fail++;
            $display("FAIL bcast_pkt: got p=%b g=%0d d=%h want p=1 g=%0d d=%h",
                     bus.pndng, bus.grant_id, bus.data_out, e.id, e.data);
         end
      end
      n_checks++;
      if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL bcast_drop: got %0d want 0", bus.drop_cnt); end
      bus.popin = 1'b1;
      step();
      bus.popin = 1'b0;
      n_checks++;
      if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL bcast_pop: pndng got %b want 0", bus.pndng); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_drop();
      test_full();
      test_reset_mid();
      test_broadcast();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
